// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit -- instruction fetch with credit-limited prefetch queue
// Optional: define FETCH_STALL_CNT_EN to add the 16-bit stall_cnt output.
// Revision: 1.0
// ============================================================================
module fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 12,
  parameter int DW    = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  output logic [AW-1:0]            mem_addr,
  output logic                     mem_rd_en,
  input  logic [DW-1:0]            mem_q,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DW-1:0]            instr,
  output logic [AW-1:0]            instr_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [DW-1:0] data_q [DEPTH];
  logic [AW-1:0] pcs_q  [DEPTH];

  logic [CW-1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Credit counts the in-flight read so a returning word always has a slot.
  assign occupancy = count_q + CW'(inflight_q);
  assign issue     = !reset && !redirect && (occupancy < C_FULL);
  assign push      = inflight_q && !redirect;
  assign pop       = (count_q != '0) && instr_ready && !redirect;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + AW'(1);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Queue storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge CLOCK_50) begin
    if (push && !reset) begin
      data_q[wr_ptr_q] <= mem_q;
      pcs_q[wr_ptr_q]  <= inflight_pc_q;
    end
  end

  assign mem_addr    = fetch_pc_q;
  assign mem_rd_en   = issue;
  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = pcs_q[rd_ptr_q];
  assign count       = count_q;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((count_q == '0) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit -- directed vector bench for fetch_unit (memory word = 0xA000+addr)
// Revision: 1.0
// ============================================================================
module tb_fetch_unit;

  logic        CLOCK_50;
  logic        reset;
  logic [11:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_q;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic [2:0]  count;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fetch_unit #(.DEPTH(4), .AW(12), .DW(16)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_q       (mem_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .count       (count)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // One-cycle-latency memory; junk word when no read was issued.
  always @(posedge CLOCK_50) begin
    if (mem_rd_en) mem_q <= 16'hA000 + {4'h0, mem_addr};
    else           mem_q <= 16'hDEAD;
  end

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [11:0] rpc;
    logic        rdy;
    logic        ev;
    logic [15:0] ei;
    logic [11:0] ep;
    logic [2:0]  ec;
    logic        er;
    logic [11:0] ea;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic add(input logic rst, input logic rdr, input logic [11:0] rpc,
                     input logic rdy, input logic ev, input logic [15:0] ei,
                     input logic [11:0] ep, input logic [2:0] ec,
                     input logic er, input logic [11:0] ea);
    vec_t v;
    v.rst = rst; v.rdr = rdr; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.er = er; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    next_cycle();
    next_cycle();

    // reset, start-up latency and streaming
    add(1,0,12'h000,1, 0,16'h0000,12'h000,3'd0,0,12'h000);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'h000);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'h001);
    add(0,0,12'h000,1, 1,16'hA000,12'h000,3'd1,1,12'h002);
    add(0,0,12'h000,1, 1,16'hA001,12'h001,3'd1,1,12'h003);
    add(0,0,12'h000,1, 1,16'hA002,12'h002,3'd1,1,12'h004);
    // back-pressure for 10 cycles: queue fills to 4, issue stops
    add(0,0,12'h000,0, 1,16'hA003,12'h003,3'd1,1,12'h005);
    add(0,0,12'h000,0, 1,16'hA003,12'h003,3'd2,1,12'h006);
    add(0,0,12'h000,0, 1,16'hA003,12'h003,3'd3,0,12'h007);
    for (int i = 0; i < 7; i++)
      add(0,0,12'h000,0, 1,16'hA003,12'h003,3'd4,0,12'h007);
    // pop while full does not free credit in the same cycle
    add(0,0,12'h000,1, 1,16'hA003,12'h003,3'd4,0,12'h007);
    add(0,0,12'h000,1, 1,16'hA004,12'h004,3'd3,1,12'h007);
    add(0,0,12'h000,1, 1,16'hA005,12'h005,3'd2,1,12'h008);
    add(0,0,12'h000,1, 1,16'hA006,12'h006,3'd2,1,12'h009);
    add(0,0,12'h000,0, 1,16'hA007,12'h007,3'd2,1,12'h00A);
    // redirect with 3 queued and one in flight
    add(0,1,12'h100,1, 1,16'hA007,12'h007,3'd3,0,12'h00B);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'h100);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'h101);
    add(0,0,12'h000,1, 1,16'hA100,12'h100,3'd1,1,12'h102);
    add(0,0,12'h000,1, 1,16'hA101,12'h101,3'd1,1,12'h103);
    // redirect near the top of the address space: wrap
    add(0,1,12'hFFE,1, 1,16'hA102,12'h102,3'd1,0,12'h104);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'hFFE);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'hFFF);
    add(0,0,12'h000,1, 1,16'hAFFE,12'hFFE,3'd1,1,12'h000);
    add(0,0,12'h000,1, 1,16'hAFFF,12'hFFF,3'd1,1,12'h001);
    add(0,0,12'h000,1, 1,16'hA000,12'h000,3'd1,1,12'h002);
    add(0,0,12'h000,1, 1,16'hA001,12'h001,3'd1,1,12'h003);
    // redirect held two cycles: last one wins
    add(0,1,12'h200,1, 1,16'hA002,12'h002,3'd1,0,12'h004);
    add(0,1,12'h300,1, 0,16'h0000,12'h000,3'd0,0,12'h200);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'h300);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'h301);
    add(0,0,12'h000,1, 1,16'hA300,12'h300,3'd1,1,12'h302);
    // build count=3, then reset mid-stream
    add(0,0,12'h000,0, 1,16'hA301,12'h301,3'd1,1,12'h303);
    add(0,0,12'h000,0, 1,16'hA301,12'h301,3'd2,1,12'h304);
    add(1,0,12'h000,1, 1,16'hA301,12'h301,3'd3,0,12'h305);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'h000);
    add(0,0,12'h000,1, 0,16'h0000,12'h000,3'd0,1,12'h001);
    add(0,0,12'h000,1, 1,16'hA000,12'h000,3'd1,1,12'h002);

    foreach (vecs[k]) begin
      reset       = vecs[k].rst;
      redirect    = vecs[k].rdr;
      redirect_pc = vecs[k].rpc;
      instr_ready = vecs[k].rdy;
      @(negedge CLOCK_50);
      check("instr_valid", k, 32'(instr_valid), 32'(vecs[k].ev));
      check("count",       k, 32'(count),       32'(vecs[k].ec));
      check("mem_rd_en",   k, 32'(mem_rd_en),   32'(vecs[k].er));
      check("mem_addr",    k, 32'(mem_addr),    32'(vecs[k].ea));
      if (vecs[k].ev) begin
        check("instr",    k, 32'(instr),    32'(vecs[k].ei));
        check("instr_pc", k, 32'(instr_pc), 32'(vecs[k].ep));
      end
      next_cycle();
    end

    // reset outranks a simultaneous redirect
    reset = 1'b1; redirect = 1'b1; redirect_pc = 12'h555; instr_ready = 1'b1;
    @(negedge CLOCK_50);
    check("rst_rdr_rd_en", 0, 32'(mem_rd_en), 32'd0);
    next_cycle();
    reset = 1'b0; redirect = 1'b0;
    @(negedge CLOCK_50);
    check("rst_rdr_addr",  1, 32'(mem_addr),  32'h000);
    check("rst_rdr_rd_en", 1, 32'(mem_rd_en), 32'd1);
    check("rst_rdr_count", 1, 32'(count),     32'd0);
    next_cycle();

`ifdef FETCH_STALL_CNT_EN
    reset = 1'b1;
    next_cycle();
    @(negedge CLOCK_50);
    check("stall_cnt_reset", 0, 32'(stall_cnt), 32'd0);
    reset = 1'b0; redirect = 1'b1; redirect_pc = 12'h000;
    repeat (5) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("stall_cnt_5", 1, 32'(stall_cnt), 32'd5);
    redirect = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
